jtag_er1_bridge: RTL and testbench

JTAG_ER1_BRIDGE -- requirements
Module: jtag_er1_bridge

---
 rtl/jtag_er1_bridge.sv | 142 ++++++++++++++
 tb/tb_jtag_er1_bridge.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_er1_bridge.sv
// ER1 user-register bridge: a 16-bit JTAG scan register turned into single register-bus
// transactions, with the JTAG pins synchronized into the clk domain.
module jtag_er1_bridge #(
    parameter int unsigned TMO_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       jtck,
    input  logic       jtdi,
    input  logic       jshift,
    input  logic       jupdate,
    input  logic       jrstn,
    input  logic       jce1,
    output logic       jtdo1,
    output logic       bus_req,
    output logic       bus_we,
    output logic [6:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic       bus_ack,
    input  logic [7:0] bus_rdata,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [7:0] TMO = 8'(TMO_CYCLES);

    // bit order: {jce1, jrstn, jupdate, jshift, jtdi, jtck}
    logic [5:0] pins, s1, s2;
    logic [1:0] s3;          // {jupdate, jtck} third stage for edge detection

    state_t      state;
    logic [15:0] sr;
    logic [7:0]  rdata;
    logic [7:0]  cnt;
    logic        ovf, tmo, er1_sel;

    logic tck_rise, upd_rise, tdi_s, shift_s, rstn_s, ce1_s;
    logic capture, shift_en, cmd, ovf_set, tmo_set;
    logic [7:0] cnt_nxt;

    assign pins = {jce1, jrstn, jupdate, jshift, jtdi, jtck};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= pins;
            s2 <= s1;
            s3 <= {s2[3], s2[0]};
        end
    end

    assign tck_rise = s2[0] & ~s3[0];
    assign upd_rise = s2[3] & ~s3[1];
    assign tdi_s    = s2[1];
    assign shift_s  = s2[2];
    assign rstn_s   = s2[4];
    assign ce1_s    = s2[5];

    assign capture  = tck_rise & ce1_s & ~shift_s;
    assign shift_en = tck_rise & ce1_s & shift_s;
    assign cmd      = upd_rise & er1_sel & rstn_s;
    assign cnt_nxt  = cnt + 8'd1;
    assign ovf_set  = cmd & (state != IDLE);
    // ack takes priority over a timeout landing in the same cycle
    assign tmo_set  = (state == REQ) & ~bus_ack & (cnt_nxt == TMO);

    assign jtdo1 = sr[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sr        <= '0;
            rdata     <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            tmo       <= 1'b0;
            er1_sel   <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            if (!rstn_s) begin
                sr      <= '0;
                er1_sel <= 1'b0;
            end else begin
                if (capture)
                    sr <= {busy, ovf, tmo, 5'b0, rdata};
                else if (shift_en)
                    sr <= {tdi_s, sr[15:1]};
                if (upd_rise)
                    er1_sel <= 1'b0;
                else if (tck_rise && ce1_s)
                    er1_sel <= 1'b1;
            end

            // a capture clears the flags it has just sampled; jrstn overrides everything
            ovf <= rstn_s & ((ovf & ~capture) | ovf_set);
            tmo <= rstn_s & ((tmo & ~capture) | tmo_set);

            case (state)
                IDLE: begin
                    if (cmd) begin
                        bus_we    <= sr[15];
                        bus_addr  <= sr[14:8];
                        bus_wdata <= sr[7:0];
                        bus_req   <= 1'b1;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    cnt <= cnt_nxt;
                    if (bus_ack) begin
                        if (!bus_we)
                            rdata <= bus_rdata;
                        bus_req <= 1'b0;
                        state   <= DONE;
                    end else if (cnt_nxt == TMO) begin
                        rdata   <= 8'hFF;
                        bus_req <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    cnt     <= '0;
                    bus_req <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_er1_bridge.sv
// Directed bench for jtag_er1_bridge: table of scan/bus transactions plus hand-written
// sequences for timeout, ack/timeout collision, overflow, jrstn and rst_n corners.
module tb_jtag_er1_bridge;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       jtck, jtdi, jshift, jupdate, jrstn, jce1;
    logic       jtdo1;
    logic       bus_req, bus_we, busy;
    logic [6:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_ack;
    logic [7:0] bus_rdata;

    int passed = 0;
    int total  = 0;

    jtag_er1_bridge #(.TMO_CYCLES(255)) dut (
        .clk(clk), .rst_n(rst_n),
        .jtck(jtck), .jtdi(jtdi), .jshift(jshift), .jupdate(jupdate),
        .jrstn(jrstn), .jce1(jce1), .jtdo1(jtdo1),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] din;
        int          ack_dly;
        logic [7:0]  rd;
        logic        we;
        logic [6:0]  addr;
        logic [7:0]  wdata;
        logic [15:0] cap;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // capture, then 16 shifts; dout collects jtdo1 LSB first
    task automatic scan(input logic [15:0] din, output logic [15:0] dout);
        @(negedge clk);
        jce1 = 1'b1; jshift = 1'b0;
        #20 jtck = 1'b1; #50 jtck = 1'b0; #30;
        for (int i = 0; i < 16; i++) begin
            jshift = 1'b1; jtdi = din[i];
            #20 dout[i] = jtdo1; jtck = 1'b1;
            #50 jtck = 1'b0; #30;
        end
        jshift = 1'b0; jce1 = 1'b0; jtdi = 1'b0;
    endtask

    // scan then raise jupdate; returns at the first negedge with bus_req=1
    task automatic issue(input logic [15:0] din, output logic [15:0] dout, output logic ok);
        scan(din, dout);
        jupdate = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            ok = bus_req;
        end
        jupdate = 1'b0;
    endtask

    task automatic update_pulse();
        jce1 = 1'b0; jupdate = 1'b1;
        #50 jupdate = 1'b0; #50;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] cap;
        logic        ok;
        logic        seen;
        int          n;

        vecs[0] = '{16'h8A5C, 3, 8'h77, 1'b1, 7'h0A, 8'h5C, 16'h0000};
        vecs[1] = '{16'h0A00, 2, 8'h3C, 1'b0, 7'h0A, 8'h00, 16'h0000};
        vecs[2] = '{16'hFFA5, 1, 8'h00, 1'b1, 7'h7F, 8'hA5, 16'h003C};
        vecs[3] = '{16'h1234, 5, 8'hC3, 1'b0, 7'h12, 8'h34, 16'h003C};
        vecs[4] = '{16'h0000, 0, 8'h5A, 1'b0, 7'h00, 8'h00, 16'h00C3};

        rst_n = 1'b0; jtck = 1'b0; jtdi = 1'b0; jshift = 1'b0; jupdate = 1'b0;
        jrstn = 1'b1; jce1 = 1'b0; bus_ack = 1'b0; bus_rdata = '0;

        repeat (3) @(negedge clk);
        chk("rst_jtdo1", jtdo1, 0);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            issue(vecs[v].din, cap, ok);
            chk($sformatf("v%0d_cap", v), cap, vecs[v].cap);
            chk($sformatf("v%0d_req", v), ok, 1);
            chk($sformatf("v%0d_we", v), bus_we, vecs[v].we);
            chk($sformatf("v%0d_addr", v), bus_addr, vecs[v].addr);
            chk($sformatf("v%0d_wdata", v), bus_wdata, vecs[v].wdata);
            repeat (vecs[v].ack_dly) @(negedge clk);
            chk($sformatf("v%0d_req_held", v), bus_req, 1);
            chk($sformatf("v%0d_addr_held", v), bus_addr, vecs[v].addr);
            bus_rdata = vecs[v].rd; bus_ack = 1'b1;
            @(negedge clk);
            bus_ack = 1'b0;
            chk($sformatf("v%0d_req_drop", v), bus_req, 0);
            chk($sformatf("v%0d_busy_done", v), busy, 1);
            @(negedge clk);
            chk($sformatf("v%0d_busy_idle", v), busy, 0);
        end
        scan(16'h0000, cap);
        chk("tbl_final_cap", cap, 16'h005A);

        // timeout: bus_req must stay high exactly 255 cycles
        issue(16'h0100, cap, ok);
        chk("tmo_issue_cap", cap, 16'h005A);
        chk("tmo_req", ok, 1);
        n = 0;
        while (bus_req === 1'b1 && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk("tmo_len", 16'(n), 16'd255);
        repeat (3) @(negedge clk);
        scan(16'h0000, cap);
        chk("tmo_cap1", cap, 16'h20FF);
        scan(16'h0000, cap);
        chk("tmo_cap2", cap, 16'h00FF);

        // ack arrives in the very cycle the counter reaches TMO_CYCLES
        issue(16'h0200, cap, ok);
        chk("coll_req", ok, 1);
        repeat (254) @(negedge clk);
        chk("coll_req_before", bus_req, 1);
        bus_rdata = 8'h9B; bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("coll_req_drop", bus_req, 0);
        repeat (3) @(negedge clk);
        scan(16'h0000, cap);
        chk("coll_cap", cap, 16'h009B);

        // second update while the first is pending is dropped and sets ovf
        issue(16'h8102, cap, ok);
        chk("ovf_issue_cap", cap, 16'h009B);
        chk("ovf_req", ok, 1);
        scan(16'h8203, cap);
        chk("ovf_busy_cap", cap, 16'h809B);
        update_pulse();
        chk("ovf_addr_kept", bus_addr, 7'h01);
        chk("ovf_wdata_kept", bus_wdata, 8'h02);
        @(negedge clk);
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("ovf_req_drop", bus_req, 0);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            seen |= bus_req;
        end
        chk("ovf_no_second", seen, 0);
        scan(16'h0000, cap);
        chk("ovf_cap", cap, 16'h409B);

        // jrstn clears SR/er1_sel but the bus transaction completes
        issue(16'h0005, cap, ok);
        chk("jr_issue_cap", cap, 16'h009B);
        chk("jr_req", ok, 1);
        chk("jr_tdo_before", jtdo1, 1);
        jrstn = 1'b0;
        repeat (4) @(negedge clk);
        jrstn = 1'b1;
        repeat (4) @(negedge clk);
        chk("jr_tdo_after", jtdo1, 0);
        chk("jr_req_kept", bus_req, 1);
        bus_rdata = 8'h11; bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("jr_req_drop", bus_req, 0);
        @(negedge clk);
        chk("jr_busy_idle", busy, 0);
        update_pulse();
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen |= bus_req;
        end
        chk("jr_upd_ignored", seen, 0);
        scan(16'h0000, cap);
        chk("jr_cap", cap, 16'h0011);

        // rst_n mid-REQ drops bus_req without waiting for a clock edge
        issue(16'h8306, cap, ok);
        chk("rr_issue_cap", cap, 16'h0011);
        chk("rr_req", ok, 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rr_req_async", bus_req, 0);
        chk("rr_busy_async", busy, 0);
        chk("rr_we_async", bus_we, 0);
        chk("rr_addr_async", bus_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rr_req_after", bus_req, 0);
        scan(16'h0000, cap);
        chk("rr_cap", cap, 16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
